// File: rtl/breakout_pkg.sv
// Shared breakout video-path definitions: colour type, palette constants and
// wall side indices.
package breakout_pkg;

  typedef logic [5:0] color_t;  // BBGGRR

  localparam color_t BLACK   = 6'h00;
  localparam color_t RED     = 6'h03;
  localparam color_t GREEN   = 6'h0C;
  localparam color_t YELLOW  = 6'h0F;
  localparam color_t BLUE    = 6'h30;
  localparam color_t MAGENTA = 6'h33;
  localparam color_t CYAN    = 6'h3C;
  localparam color_t WHITE   = 6'h3F;

  localparam int SIDE_LEFT   = 0;
  localparam int SIDE_RIGHT  = 1;
  localparam int SIDE_TOP    = 2;
  localparam int SIDE_BOTTOM = 3;
  localparam int NUM_SIDES   = 4;

endpackage

// File: rtl/border_flash_renderer_flash_timer.sv
// Per-wall flash frame counter: load restarts the flash, tick counts a frame
// down, saturating at zero.
module flash_timer #(
  parameter int FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic active
);

  localparam logic [7:0] FRAMES_L = 8'(FRAMES);

  logic [7:0] cnt_q, cnt_d;

  // A load always wins over a same-cycle tick so a hit on frame_start keeps
  // the full flash length.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = FRAMES_L;
    end else if (tick && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != 8'd0);

endmodule

// File: rtl/border_flash_renderer.sv
// Border pixel generator: decodes the four walls from the beam position and
// registers in_border/color with one pixel of latency.
module border_flash_renderer
  import breakout_pkg::*;
#(
  parameter int     H_BITS            = 10,
  parameter int     V_BITS            = 9,
  parameter int     BORDER_WIDTH_LOG2 = 3,
  parameter int     BORDER_LEFT       = 0,
  parameter int     BORDER_RIGHT      = 632,
  parameter int     BORDER_TOP        = 0,
  parameter int     BORDER_BOTTOM     = 472,
  parameter bit     BOTTOM_EN         = 1'b0,
  parameter color_t BORDER_COLOR      = 6'b111111,
  parameter color_t FLASH_COLOR       = 6'b000011,
  parameter int     FLASH_FRAMES      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [H_BITS-1:0] hpos,
  input  logic [V_BITS-1:0] vpos,
  input  logic              frame_start,
  input  logic [3:0]        hit,
  output logic              in_border,
  output logic [5:0]        color,
  output logic [3:0]        flashing
);

  localparam logic [H_BITS-1:0] LEFT_L   = H_BITS'(BORDER_LEFT);
  localparam logic [H_BITS-1:0] RIGHT_L  = H_BITS'(BORDER_RIGHT);
  localparam logic [V_BITS-1:0] TOP_L    = V_BITS'(BORDER_TOP);
  localparam logic [V_BITS-1:0] BOTTOM_L = V_BITS'(BORDER_BOTTOM);

  logic [3:0] match;
  logic [3:0] load;
  logic       in_border_q, in_border_d;
  color_t     color_q, color_d;

  // Shifting both sides drops the sub-thickness bits, so unaligned
  // parameter low bits are ignored.
  always_comb begin
    match              = '0;
    match[SIDE_LEFT]   = (hpos >> BORDER_WIDTH_LOG2) == (LEFT_L >> BORDER_WIDTH_LOG2);
    match[SIDE_RIGHT]  = (hpos >> BORDER_WIDTH_LOG2) == (RIGHT_L >> BORDER_WIDTH_LOG2);
    match[SIDE_TOP]    = (vpos >> BORDER_WIDTH_LOG2) == (TOP_L >> BORDER_WIDTH_LOG2);
    match[SIDE_BOTTOM] = BOTTOM_EN &&
                         ((vpos >> BORDER_WIDTH_LOG2) == (BOTTOM_L >> BORDER_WIDTH_LOG2));
  end

  always_comb begin
    load              = hit;
    load[SIDE_BOTTOM] = BOTTOM_EN ? hit[SIDE_BOTTOM] : 1'b0;
  end

  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    flash_timer #(
      .FRAMES (FLASH_FRAMES)
    ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[s]),
      .tick   (frame_start),
      .active (flashing[s])
    );
  end

  // Flash colour takes priority whenever any matching wall is flashing,
  // including corners shared with a steady wall.
  always_comb begin
    in_border_d = |match;
    color_d     = BLACK;
    if (|(match & flashing)) begin
      color_d = FLASH_COLOR;
    end else if (in_border_d) begin
      color_d = BORDER_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_border_q <= 1'b0;
      color_q     <= BLACK;
    end else begin
      in_border_q <= in_border_d;
      color_q     <= color_d;
    end
  end

  assign in_border = in_border_q;
  assign color     = color_q;

endmodule

// File: doc/border_flash_renderer.md
# border_flash_renderer

Parametrised border pixel generator for the breakout video path. It sits beside the paddle/brick/ball generators and feeds the colour mux. Per side it decodes the left, right, top and optional bottom walls at a configurable power-of-two thickness. Each wall flashes in an alternate colour for a programmable number of frames after a ball-hit pulse. Outputs are registered with one pixel clock of latency.

## Interface
Parameters:
- `H_BITS`, 10: width of horizontal position.
- `V_BITS`, 9: width of vertical position.
- `BORDER_WIDTH_LOG2`, 3: wall thickness = 2^n pixels.
- `BORDER_LEFT`, 0: left wall start (H_BITS, aligned to 2^n).
- `BORDER_RIGHT`, 632: right wall start.
- `BORDER_TOP`, 0: top wall start (V_BITS).
- `BORDER_BOTTOM`, 472: bottom wall start.
- `BOTTOM_EN`, 0: 1 = bottom wall drawn and flashable.
- `BORDER_COLOR`, 6'b111111: steady colour, BBGGRR.
- `FLASH_COLOR`, 6'b000011: flash colour, BBGGRR.
- `FLASH_FRAMES`, 8: frames per flash, 0..255; 0 disables flashing.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset. Reset is asynchronous and active-low.
- `hpos`, in, H_BITS: current pixel column.
- `vpos`, in, V_BITS: current pixel row.
- `frame_start`, in, 1: one-cycle pulse, once per frame.
- `hit`, in, 4: one-cycle hit pulses. Bit 0 = left, 1 = right, 2 = top, 3 = bottom.
- `in_border`, out, 1: registered; pixel lies in a drawn wall.
- `color`, out, 6: registered wall colour. It is 0 when `in_border` = 0.
- `flashing`, out, 4: per-side flash active; this is the counter ≠ 0 state.

## Operation
- **Side decode.** A side matches when the position bits above `BORDER_WIDTH_LOG2` equal the same bits of the side's start parameter. Left and right compare `hpos`; top and bottom compare `vpos`. The bottom match is forced to 0 when `BOTTOM_EN` = 0.
- **Flash counter.** Each side has an 8-bit counter `cnt[s]`.
  - `hit[s]` = 1 loads `FLASH_FRAMES`.
  - Otherwise `frame_start` = 1 with `cnt[s]` ≠ 0 decrements it.
  - Otherwise it holds.
  - `hit[s]` and `frame_start` in the same cycle: the load wins and no decrement occurs.
  - A re-hit while the counter is non-zero restarts it at `FLASH_FRAMES`.
  - The counter never wraps below 0.
- **Bottom counter when disabled.** With `BOTTOM_EN` = 0, `hit[3]` is ignored and `cnt[3]` stays 0.
- **Flashing output.** `flashing[s]` = (`cnt[s]` ≠ 0). It is combinational from the counter register, so it is valid the cycle after the hit.
- **Colour select.** Let `m` be the 4-bit side-match vector.
  - `in_border` = |`m`.
  - If any bit of (`m` & `flashing`) is set, colour = `FLASH_COLOR`; this applies at corners too.
  - Otherwise, in the border, colour = `BORDER_COLOR`; outside it, 0.
  - Flash state is sampled at the same edge as the position, so one pixel row may mix old and new state at a hit.
- **Width rules.** All comparisons are unsigned on bits [H_BITS-1:BORDER_WIDTH_LOG2] or [V_BITS-1:BORDER_WIDTH_LOG2]. Parameter low bits below the thickness are ignored.

## Timing
- Latency: `in_border` and `color` reflect the `hpos`/`vpos` presented one `clk` edge earlier. The colour mux must delay the other layers to match.
- `hit` to `flashing`: 1 cycle. Flash ends on the `FLASH_FRAMES`-th `frame_start` after the hit.
- Reset (async assert, sync release): `in_border` = 0, `color` = 0, `flashing` = 0, all counters 0.
- Reset mid-flash aborts the flash immediately.
- `FLASH_FRAMES` = 0: a hit loads 0, so `flashing` never rises.

## Structure
- Shared package `breakout_pkg`:
  - colour type (6-bit BBGGRR);
  - colour constants (WHITE, RED, …);
  - side index constants (SIDE_LEFT = 0, SIDE_RIGHT = 1, SIDE_TOP = 2, SIDE_BOTTOM = 3).
- Sub-module `flash_timer`:
  - ports `clk`, `rst_n`, `load`, `tick`, `active`;
  - parameter `FRAMES`;
  - instantiated four times, bottom instance with `load` tied low when `BOTTOM_EN` = 0.
- The top level holds the side decode and the output register stage.

## Test plan
- Reset held, hpos = 0, vpos = 100 → `in_border` = 0, `color` = 0. After release, hpos = 0 → next cycle `in_border` = 1, `color` = 6'h3F.
- hpos = 320, vpos = 240 → `in_border` = 0, `color` = 0. hpos = 639 → `in_border` = 1. hpos = 631 → `in_border` = 0.
- Pulse `hit[0]`, then issue 8 `frame_start` pulses:
  - `flashing[0]` = 1 from the next cycle until the cycle after the 8th `frame_start`;
  - hpos = 3 gives `color` = 6'h03 during that window and 6'h3F after it.
- `hit[2]` and `frame_start` in the same cycle → `cnt[2]` = 8, not 7.
- Re-hit after 5 frames → 8 more frames are needed before `flashing[2]` = 0.
- Corner hpos = 0, vpos = 0 with only top flashing → `color` = 6'h03.
- Bottom test with `BOTTOM_EN` = 0, vpos = 475 and `hit[3]` pulsed → `in_border` = 0 and `flashing[3]` = 0.
- Assert `rst_n` mid-flash → `flashing` = 0 immediately.
